// File: rtl/mem_arbiter_if.sv
// Shared bus bundle between mem_arbiter, the I/D cache controllers and the memory port.
// slave is the arbiter's view; master is the view of the caches and memory around it.
interface mem_arbiter_if;
    logic        i_readM;
    logic [13:0] i_address;
    logic        i_ack;
    logic [63:0] i_rdata;

    logic        d_readM;
    logic        d_writeM;
    logic [13:0] d_address;
    logic [63:0] d_wdata;
    logic        d_ack;
    logic [63:0] d_rdata;

    logic        m_read;
    logic        m_write;
    logic [13:0] m_address;
    logic [63:0] m_wdata;
    logic [63:0] m_rdata;

    modport slave (
        input  i_readM, i_address, d_readM, d_writeM, d_address, d_wdata, m_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, m_read, m_write, m_address, m_wdata
    );

    modport master (
        output i_readM, i_address, d_readM, d_writeM, d_address, d_wdata, m_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, m_read, m_write, m_address, m_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency 64-bit line memory port between
// the I-cache (reads) and D-cache (reads and writes), with saturating statistics.
module mem_arbiter #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    mem_arbiter_if.slave     bus,
    output logic [CNT_W-1:0] i_grant_cnt,
    output logic [CNT_W-1:0] d_grant_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, ACK} state_t;

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic             r_last_d;
    logic             r_m_read;
    logic             r_m_write;
    logic [13:0]      r_addr;
    logic [63:0]      r_wdata;
    logic             r_i_ack;
    logic             r_d_ack;
    logic [63:0]      r_i_rdata;
    logic [63:0]      r_d_rdata;
    logic [CNT_W-1:0] r_i_gcnt;
    logic [CNT_W-1:0] r_d_gcnt;
    logic [CNT_W-1:0] r_wait;

    logic             w_i_req;
    logic             w_d_req;
    logic             w_gnt_i;
    logic             w_gnt_d;
    logic             w_i_wait;
    logic             w_d_wait;
    logic [1:0]       w_wait_inc;
    logic [CNT_W:0]   w_wait_sum;
    logic [CNT_W-1:0] w_wait_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign w_i_req = bus.i_readM;
    assign w_d_req = bus.d_readM | bus.d_writeM;
    // On a tie the side that was not granted last wins; last_grant resets to I.
    assign w_gnt_d = (r_state == IDLE) && w_d_req && (!w_i_req || !r_last_d);
    assign w_gnt_i = (r_state == IDLE) && w_i_req && !w_gnt_d;

    // A side is being serviced on its grant edge, while granted, and in its own ACK cycle.
    assign w_i_wait = w_i_req && !(w_gnt_i || r_state == GNT_I || (r_state == ACK && !r_last_d));
    assign w_d_wait = w_d_req && !(w_gnt_d || r_state == GNT_D || (r_state == ACK &&  r_last_d));
    assign w_wait_inc = {1'b0, w_i_wait} + {1'b0, w_d_wait};
    assign w_wait_sum = {1'b0, r_wait} + (CNT_W+1)'(w_wait_inc);
    assign w_wait_nxt = w_wait_sum[CNT_W] ? '1 : w_wait_sum[CNT_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_last_d  <= 1'b0;
            r_m_read  <= 1'b0;
            r_m_write <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_i_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_i_gcnt  <= '0;
            r_d_gcnt  <= '0;
            r_wait    <= '0;
        end else begin
            r_wait <= w_wait_nxt;
            case (r_state)
                IDLE: begin
                    if (w_gnt_d) begin
                        r_state   <= GNT_D;
                        r_addr    <= bus.d_address;
                        r_wdata   <= bus.d_wdata;
                        r_m_read  <= !bus.d_writeM;
                        r_m_write <= bus.d_writeM;
                        r_cnt     <= 4'(LATENCY - 1);
                    end else if (w_gnt_i) begin
                        r_state   <= GNT_I;
                        r_addr    <= bus.i_address;
                        r_m_read  <= 1'b1;
                        r_m_write <= 1'b0;
                        r_cnt     <= 4'(LATENCY - 1);
                    end
                end
                GNT_I: begin
                    if (!w_i_req) begin
                        r_state  <= IDLE;
                        r_m_read <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_state   <= ACK;
                        r_m_read  <= 1'b0;
                        r_i_rdata <= bus.m_rdata;
                        r_i_ack   <= 1'b1;
                        r_last_d  <= 1'b0;
                        r_i_gcnt  <= sat_inc(r_i_gcnt);
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                GNT_D: begin
                    if (!w_d_req) begin
                        r_state   <= IDLE;
                        r_m_read  <= 1'b0;
                        r_m_write <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_state   <= ACK;
                        r_m_read  <= 1'b0;
                        r_m_write <= 1'b0;
                        if (!r_m_write) r_d_rdata <= bus.m_rdata;
                        r_d_ack   <= 1'b1;
                        r_last_d  <= 1'b1;
                        r_d_gcnt  <= sat_inc(r_d_gcnt);
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ACK: begin
                    r_state <= IDLE;
                    r_i_ack <= 1'b0;
                    r_d_ack <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.m_read    = r_m_read;
    assign bus.m_write   = r_m_write;
    assign bus.m_address = r_addr;
    assign bus.m_wdata   = r_wdata;
    assign bus.i_ack     = r_i_ack;
    assign bus.d_ack     = r_d_ack;
    assign bus.i_rdata   = r_i_rdata;
    assign bus.d_rdata   = r_d_rdata;
    assign i_grant_cnt   = r_i_gcnt;
    assign d_grant_cnt   = r_d_gcnt;
    assign wait_cnt      = r_wait;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: LATENCY=4/CNT_W=16 main instance plus a
// LATENCY=1/CNT_W=2 instance for single-cycle strobes and counter saturation.
module tb_mem_arbiter;
    localparam int unsigned LAT = 4;
    localparam logic [63:0] BAD = 64'hBAD0_BAD0_BAD0_BAD0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();
    mem_arbiter_if bus2 ();
    logic [15:0] i_gc, d_gc, w_c;
    logic [1:0]  i_gc2, d_gc2, w_c2;

    mem_arbiter #(.LATENCY(LAT), .CNT_W(16)) dut (
        .clk(clk), .reset(rst), .bus(bus),
        .i_grant_cnt(i_gc), .d_grant_cnt(d_gc), .wait_cnt(w_c)
    );
    mem_arbiter #(.LATENCY(1), .CNT_W(2)) dut2 (
        .clk(clk), .reset(rst), .bus(bus2),
        .i_grant_cnt(i_gc2), .d_grant_cnt(d_gc2), .wait_cnt(w_c2)
    );

    // Memory model: read data is only valid in the last strobe cycle.
    logic [63:0] mem [0:16383];
    int unsigned run;
    always @(posedge clk or posedge rst) begin
        if (rst) run <= 0;
        else if (bus.m_read || bus.m_write) run <= run + 1;
        else run <= 0;
    end
    assign bus.m_rdata  = (bus.m_read && run == LAT - 1) ? mem[bus.m_address] : BAD;
    assign bus2.m_rdata = bus2.m_read ? mem[bus2.m_address] : BAD;

    int unsigned n_pass = 0, n_total = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    typedef struct {
        logic [13:0] addr;
        logic        wr;
        logic [63:0] wdata;
        logic [63:0] rdata;
    } txn_t;
    txn_t sb_i[$];
    txn_t sb_d[$];
    logic [63:0] exp_i_rd, exp_d_rd;

    // Monitor: records each strobe window and scores every ack against the queues.
    int unsigned cyc = 0, i_ack_cyc = 0, d_ack_cyc = 0, exp_i_cnt = 0, exp_d_cnt = 0;
    int unsigned mon_len = 0;
    logic        strobe_prev = 1'b0, mon_wr = 1'b0, mon_stable = 1'b1;
    logic [13:0] mon_addr = '0;
    logic [63:0] mon_wdata = '0;
    always @(negedge clk) begin : mon
        txn_t t;
        cyc++;
        if (rst) begin
            strobe_prev = 1'b0;
            exp_i_cnt = 0;
            exp_d_cnt = 0;
            sb_i.delete();
            sb_d.delete();
        end else begin
            if (bus.m_read || bus.m_write) begin
                if (!strobe_prev) begin
                    mon_addr = bus.m_address; mon_wdata = bus.m_wdata;
                    mon_wr = bus.m_write; mon_len = 1; mon_stable = 1'b1;
                end else begin
                    mon_len++;
                    if (bus.m_address !== mon_addr || bus.m_wdata !== mon_wdata || bus.m_write !== mon_wr)
                        mon_stable = 1'b0;
                end
            end
            strobe_prev = bus.m_read || bus.m_write;
            if (bus.i_ack) begin
                i_ack_cyc = cyc;
                if (sb_i.size() == 0) check("i_ack_unexpected", 64'(bus.i_ack), 64'd0);
                else begin
                    t = sb_i.pop_front();
                    exp_i_cnt++;
                    check("i_rdata", bus.i_rdata, t.rdata);
                    check("i_m_address", 64'(mon_addr), 64'(t.addr));
                    check("i_strobe_len", 64'(mon_len), 64'(LAT));
                    check("i_strobe_stable", 64'(mon_stable), 64'd1);
                    check("i_strobe_kind", 64'(mon_wr), 64'd0);
                    check("i_grant_cnt", 64'(i_gc), 64'(exp_i_cnt));
                end
            end
            if (bus.d_ack) begin
                d_ack_cyc = cyc;
                if (sb_d.size() == 0) check("d_ack_unexpected", 64'(bus.d_ack), 64'd0);
                else begin
                    t = sb_d.pop_front();
                    exp_d_cnt++;
                    check("d_rdata", bus.d_rdata, t.rdata);
                    check("d_m_address", 64'(mon_addr), 64'(t.addr));
                    check("d_strobe_len", 64'(mon_len), 64'(LAT));
                    check("d_strobe_stable", 64'(mon_stable), 64'd1);
                    check("d_strobe_kind", 64'(mon_wr), 64'(t.wr));
                    if (t.wr) check("d_m_wdata", mon_wdata, t.wdata);
                    check("d_grant_cnt", 64'(d_gc), 64'(exp_d_cnt));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for the ack, then keeps the request up through the ACK cycle.
    task automatic wait_ack(input logic side);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            tick();
            if (side ? bus.d_ack : bus.i_ack) got = 1'b1;
        end
        if (got) tick();
        else check(side ? "d_ack_timeout" : "i_ack_timeout", 64'd0, 64'd1);
    endtask

    task automatic i_read(input logic [13:0] a);
        txn_t t;
        t.addr = a; t.wr = 1'b0; t.wdata = '0; t.rdata = mem[a];
        sb_i.push_back(t);
        exp_i_rd = mem[a];
        bus.i_address = a;
        bus.i_readM = 1'b1;
        wait_ack(1'b0);
        bus.i_readM = 1'b0;
    endtask

    task automatic d_op(input logic [13:0] a, input logic rd, input logic wr, input logic [63:0] wd);
        txn_t t;
        t.addr = a; t.wr = wr; t.wdata = wd; t.rdata = wr ? exp_d_rd : mem[a];
        sb_d.push_back(t);
        if (!wr) exp_d_rd = mem[a];
        bus.d_address = a; bus.d_wdata = wd;
        bus.d_readM = rd; bus.d_writeM = wr;
        wait_ack(1'b1);
        bus.d_readM = 1'b0;
        bus.d_writeM = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_readM = 1'b0; bus.d_readM = 1'b0; bus.d_writeM = 1'b0;
        bus2.i_readM = 1'b0; bus2.d_readM = 1'b0; bus2.d_writeM = 1'b0;
        exp_i_rd = '0;
        exp_d_rd = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c1, seen, nstb;
        logic got;
        for (int a = 0; a < 16384; a++) mem[a] = 64'(a) * 64'h0001_0003_0007_000B + 64'h1234;
        mem[14'h0123] = 64'hDEAD_BEEF_0000_1111;
        bus.i_address = '0; bus.d_address = '0; bus.d_wdata = '0;
        bus2.i_address = '0; bus2.d_address = '0; bus2.d_wdata = '0;
        do_reset();

        check("rst_m_read", 64'(bus.m_read), 64'd0);
        check("rst_m_write", 64'(bus.m_write), 64'd0);
        check("rst_i_ack", 64'(bus.i_ack), 64'd0);
        check("rst_d_ack", 64'(bus.d_ack), 64'd0);
        check("rst_m_address", 64'(bus.m_address), 64'd0);
        check("rst_m_wdata", bus.m_wdata, 64'd0);
        check("rst_i_rdata", bus.i_rdata, 64'd0);
        check("rst_d_rdata", bus.d_rdata, 64'd0);
        check("rst_counters", {16'd0, i_gc, d_gc, w_c}, 64'd0);

        i_read(14'h0123);
        check("single_i_wait_cnt", 64'(w_c), 64'd0);
        d_op(14'h3FFF, 1'b0, 1'b1, 64'hA5A5_A5A5_A5A5_A5A5);
        d_op(14'h0200, 1'b1, 1'b0, 64'd0);
        d_op(14'h0201, 1'b1, 1'b1, 64'h0F0F_1234_5678_9ABC);

        // Tie right after reset: D first, I follows LATENCY+2 cycles later.
        do_reset();
        fork
            i_read(14'h0010);
            d_op(14'h0020, 1'b1, 1'b0, 64'd0);
        join
        check("tie_i_after_d", 64'(i_ack_cyc - d_ack_cyc), 64'(LAT + 2));
        check("tie_wait_cnt", 64'(w_c), 64'd6);

        // With D granted last, the next tie goes to I.
        d_op(14'h0030, 1'b1, 1'b0, 64'd0);
        fork
            i_read(14'h0031);
            d_op(14'h0032, 1'b0, 1'b1, 64'h1111_2222_3333_4444);
        join
        check("tie_i_first", 64'(d_ack_cyc - i_ack_cyc), 64'(LAT + 2));

        // I request held through ACK: the regrant only comes after IDLE resamples it.
        begin
            txn_t t;
            t.addr = 14'h0040; t.wr = 1'b0; t.wdata = '0; t.rdata = mem[14'h0040];
            sb_i.push_back(t);
            sb_i.push_back(t);
            exp_i_rd = mem[14'h0040];
            bus.i_address = 14'h0040;
            bus.i_readM = 1'b1;
            wait_ack(1'b0);
            c1 = i_ack_cyc;
            wait_ack(1'b0);
            bus.i_readM = 1'b0;
            check("hold_regrant_spacing", 64'(i_ack_cyc - c1), 64'(LAT + 2));
        end

        // D read abort in its second strobe cycle.
        bus.d_address = 14'h0555; bus.d_readM = 1'b1;
        seen = 0;
        for (int k = 0; k < 20 && seen < 2; k++) begin
            tick();
            if (bus.m_read) seen++;
        end
        bus.d_readM = 1'b0;
        tick();
        check("abort_strobe_drop", 64'(bus.m_read), 64'd0);
        repeat (8) tick();
        check("abort_d_grant_cnt", 64'(d_gc), 64'(exp_d_cnt));
        check("abort_d_rdata", bus.d_rdata, exp_d_rd);
        check("abort_d_ack", 64'(bus.d_ack), 64'd0);

        // Asynchronous reset in the middle of an I grant.
        begin
            txn_t t;
            t.addr = 14'h0042; t.wr = 1'b0; t.wdata = '0; t.rdata = mem[14'h0042];
            sb_i.push_back(t);
        end
        bus.i_address = 14'h0042; bus.i_readM = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            if (bus.m_read) got = 1'b1;
        end
        check("async_pre_grant", 64'(got), 64'd1);
        #2 rst = 1'b1;
        bus.i_readM = 1'b0;
        #1;
        check("async_m_read", 64'(bus.m_read), 64'd0);
        check("async_i_ack", 64'(bus.i_ack), 64'd0);
        check("async_counters", {16'd0, i_gc, d_gc, w_c}, 64'd0);
        check("async_i_rdata", bus.i_rdata, 64'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        exp_i_rd = '0;
        exp_d_rd = '0;
        tick();
        i_read(14'h0123);

        // LATENCY=1 instance: one-cycle strobe and 2-bit saturating counters.
        for (int n = 0; n < 4; n++) begin
            logic [13:0] a2;
            a2 = 14'(n + 16);
            bus2.i_address = a2;
            bus2.i_readM = 1'b1;
            nstb = 0;
            got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                tick();
                if (bus2.m_read) nstb++;
                if (bus2.i_ack) got = 1'b1;
            end
            check("l1_ack_seen", 64'(got), 64'd1);
            check("l1_strobe_len", 64'(nstb), 64'd1);
            check("l1_i_rdata", bus2.i_rdata, mem[a2]);
            check("l1_i_grant_sat", 64'(i_gc2), (n + 1 > 3) ? 64'd3 : 64'(n + 1));
            tick();
            bus2.i_readM = 1'b0;
            tick();
        end
        bus2.i_address = 14'h0050; bus2.d_address = 14'h0051;
        bus2.i_readM = 1'b1; bus2.d_readM = 1'b1;
        repeat (20) tick();
        bus2.i_readM = 1'b0; bus2.d_readM = 1'b0;
        repeat (3) tick();
        check("l1_wait_sat", 64'(w_c2), 64'd3);
        check("l1_d_grant_sat", 64'(d_gc2), 64'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
